// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA raster timing: pixel counters, active-low syncs, valid and frame_start.
// Optional pixel-clock divider enabled by defining VGA_CLKDIV_EN (CLK_DIV clk cycles per pixel).
module vga_timing_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic       pix_en,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISP);
  localparam logic [9:0] V_VIS      = 10'(V_DISP);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_DISP + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;
  logic       hsync_reg;
  logic       vsync_reg;
  logic       valid_reg;
  logic       frame_start_reg;

`ifdef VGA_CLKDIV_EN
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
    end else if (div_reg == DIV_MAX) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  assign pix_en = (div_reg == DIV_MAX);
`else
  // clk is the pixel clock; a non-positive CLK_DIV would still be a configuration error.
  generate
    if (CLK_DIV < 1) begin : g_clk_div_must_be_positive
    end
  endgenerate

  assign pix_en = 1'b1;
`endif

  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (pix_en) begin
      if (h_cnt_reg == H_MAX) begin
        h_cnt_next = '0;
        if (v_cnt_reg == V_MAX) begin
          v_cnt_next = '0;
        end else begin
          v_cnt_next = v_cnt_reg + 10'd1;
        end
      end else begin
        h_cnt_next = h_cnt_reg + 10'd1;
      end
    end
  end

  // Flags decode the next counter values so they register in the same cycle as the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg       <= H_MAX;
      v_cnt_reg       <= V_MAX;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      valid_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      h_cnt_reg       <= h_cnt_next;
      v_cnt_reg       <= v_cnt_next;
      hsync_reg       <= !((h_cnt_next >= HS_FIRST) && (h_cnt_next <= HS_LAST));
      vsync_reg       <= !((v_cnt_next >= VS_FIRST) && (v_cnt_next <= VS_LAST));
      valid_reg       <= (h_cnt_next < H_VIS) && (v_cnt_next < V_VIS);
      frame_start_reg <= pix_en && (h_cnt_reg == H_MAX) && (v_cnt_reg == V_MAX);
    end
  end

  assign h_cnt       = h_cnt_reg;
  assign v_cnt       = v_cnt_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign valid       = valid_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size and shrunken-parameter instances under random resets,
// checked every cycle against a position-from-elapsed-cycles model.
module tb_vga_timing_gen;

`ifdef VGA_CLKDIV_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [9:0] h_a, v_a, h_b, v_b;
  logic       hs_a, vs_a, va_a, pe_a, fs_a;
  logic       hs_b, vs_b, va_b, pe_b, fs_b;

  int checks = 0;
  int passed = 0;
  int c_a = 0;
  int c_b = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .h_cnt(h_a), .v_cnt(v_a), .hsync(hs_a), .vsync(vs_a),
    .valid(va_a), .pix_en(pe_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_DISP(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .h_cnt(h_b), .v_cnt(v_b), .hsync(hs_b), .vsync(vs_b),
    .valid(va_b), .pix_en(pe_b), .frame_start(fs_b)
  );

  // Edges elapsed since the last edge that sampled reset.
  always @(posedge clk) begin
    c_a <= rst_a ? 0 : c_a + 1;
    c_b <= rst_b ? 0 : c_b + 1;
  end

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit va;
    bit pe;
    bit fs;
  } exp_t;

  // After c edges out of reset, n = c/D pixels have been stepped; the raster
  // position is pixel n-1 of an endless sequence of frames.
  function automatic exp_t model(input int c, input int hd, input int hf, input int hsw, input int hb,
                                 input int vd, input int vf, input int vsw, input int vb);
    exp_t e;
    int ht, vt, n, p;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    n = c / D;
    e.pe = ((c % D) == D - 1);
    if (n == 0) begin
      e.h = ht - 1;
      e.v = vt - 1;
      e.fs = 1'b0;
    end else begin
      p = (n - 1) % (ht * vt);
      e.h = p % ht;
      e.v = p / ht;
      e.fs = ((c % D) == 0) && (p == 0);
    end
    e.hs = !((e.h >= hd + hf) && (e.h <= hd + hf + hsw - 1));
    e.vs = !((e.v >= vd + vf) && (e.v <= vd + vf + vsw - 1));
    e.va = (e.h < hd) && (e.v < vd);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      exp_t ea, eb;
      ea = model(c_a, 640, 16, 96, 48, 480, 10, 2, 33);
      eb = model(c_b, 8, 1, 2, 1, 4, 1, 1, 1);
      check("a.h_cnt", int'(h_a), ea.h);
      check("a.v_cnt", int'(v_a), ea.v);
      check("a.hsync", int'(hs_a), int'(ea.hs));
      check("a.vsync", int'(vs_a), int'(ea.vs));
      check("a.valid", int'(va_a), int'(ea.va));
      check("a.pix_en", int'(pe_a), int'(ea.pe));
      check("a.frame_start", int'(fs_a), int'(ea.fs));
      check("b.h_cnt", int'(h_b), eb.h);
      check("b.v_cnt", int'(v_b), eb.v);
      check("b.hsync", int'(hs_b), int'(eb.hs));
      check("b.vsync", int'(vs_b), int'(eb.vs));
      check("b.valid", int'(va_b), int'(eb.va));
      check("b.pix_en", int'(pe_b), int'(eb.pe));
      check("b.frame_start", int'(fs_b), int'(eb.fs));
    end
  end

  task automatic wait_a(input int target);
    while (c_a < target) @(negedge clk);
  endtask

  task automatic wait_b(input int target);
    while (c_b < target) @(negedge clk);
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, ".h"}, int'(h_a), 799);
    check({tag, ".v"}, int'(v_a), 524);
    check({tag, ".hsync"}, int'(hs_a), 1);
    check({tag, ".vsync"}, int'(vs_a), 1);
    check({tag, ".valid"}, int'(va_a), 0);
    check({tag, ".frame_start"}, int'(fs_a), 0);
  endtask

  initial begin
    int run_len, hold_len;
    repeat (3) @(negedge clk);
    started = 1'b1;
    check_a_reset("rst_hold");
    $display("reset hold: h=%0d v=%0d hsync=%0b vsync=%0b valid=%0b", h_a, v_a, hs_a, vs_a, va_a);

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (D) @(negedge clk);
    check("release.h", int'(h_a), 0);
    check("release.v", int'(v_a), 0);
    check("release.valid", int'(va_a), 1);
    check("release.frame_start", int'(fs_a), 1);
    @(negedge clk);
    check("release.frame_start_drop", int'(fs_a), 0);
    $display("release: first pixel (0,0) presented after %0d clk", D);

    wait_b(10 * D);
    check("small.h9", int'(h_b), 9);
    check("small.hsync_h9", int'(hs_b), 0);
    wait_b(13 * D);
    check("small.wrap_h", int'(h_b), 0);
    check("small.wrap_v", int'(v_b), 1);
    wait_b(61 * D);
    check("small.v5", int'(v_b), 5);
    check("small.vsync_v5", int'(vs_b), 0);
    wait_b(85 * D);
    check("small.frame_h", int'(h_b), 0);
    check("small.frame_v", int'(v_b), 0);
    check("small.frame_start", int'(fs_b), 1);
    $display("small params: H_TOTAL 12, V_TOTAL 7 timing pinned");

    wait_a(640 * D);
    check("line.valid_h639", int'(va_a), 1);
    wait_a(641 * D);
    check("line.h640", int'(h_a), 640);
    check("line.valid_h640", int'(va_a), 0);
    wait_a(656 * D);
    check("line.hsync_h655", int'(hs_a), 1);
    wait_a(657 * D);
    check("line.hsync_h656", int'(hs_a), 0);
    wait_a(752 * D);
    check("line.hsync_h751", int'(hs_a), 0);
    wait_a(753 * D);
    check("line.hsync_h752", int'(hs_a), 1);
    wait_a(800 * D);
    check("line.h799", int'(h_a), 799);
    check("line.v0", int'(v_a), 0);
    wait_a(801 * D);
    check("line.wrap_h", int'(h_a), 0);
    check("line.wrap_v", int'(v_a), 1);
    $display("line timing: one full line run");

    wait_a(1501 * D);
    check("mid.h700", int'(h_a), 700);
    check("mid.hsync_low", int'(hs_a), 0);
    rst_a = 1'b1;
    @(negedge clk);
    check_a_reset("mid_rst");
    repeat ($urandom_range(4, 1)) @(negedge clk);
    rst_a = 1'b0;
    repeat (D) @(negedge clk);
    check("mid_restart.h", int'(h_a), 0);
    check("mid_restart.v", int'(v_a), 0);
    check("mid_restart.frame_start", int'(fs_a), 1);
    $display("mid-line reset at h=700: restart at (0,0)");

    for (int i = 0; i < 8; i++) begin
      run_len = $urandom_range(2500, 200);
      hold_len = $urandom_range(5, 1);
      repeat (run_len) @(negedge clk);
      if ($urandom_range(1, 0) == 1) rst_a = 1'b1;
      if ($urandom_range(1, 0) == 1) rst_b = 1'b1;
      repeat (hold_len) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      $display("random burst %0d: ran %0d clk, reset held %0d clk", i, run_len, hold_len);
    end
    repeat (200) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
